// File: rtl/mf_clken_nco.sv
// Multi-channel NCO clock-enable generator: per-channel phase accumulators with
// double-buffered increment/phase configuration and a configuration-lock timer.
module mf_clken_nco #(
  parameter int NUM_CH      = 5,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              run,
  input  logic              cfg_wr,
  input  logic [2:0]        cfg_ch,
  input  logic              cfg_sel,
  input  logic [ACC_W-1:0]  cfg_data,
  input  logic              apply,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);

  logic [ACC_W-1:0] shadow_inc   [NUM_CH];
  logic [ACC_W-1:0] shadow_phase [NUM_CH];
  logic [ACC_W-1:0] active_inc   [NUM_CH];
  logic [ACC_W-1:0] acc          [NUM_CH];
  logic [ACC_W-1:0] byp_inc      [NUM_CH];
  logic [ACC_W-1:0] byp_phase    [NUM_CH];
  logic [ACC_W:0]   sum          [NUM_CH];
  logic [LW-1:0]    lock_cnt;
  logic [LW-1:0]    lock_nxt;
  logic             wr_ok;

  assign wr_ok = cfg_wr && (int'(cfg_ch) < NUM_CH);

  // Shadow values as they will be after this edge, so a same-cycle apply
  // picks up the word being written.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      byp_inc[i]   = shadow_inc[i];
      byp_phase[i] = shadow_phase[i];
      if (wr_ok && (cfg_ch == 3'(i))) begin
        if (cfg_sel) byp_phase[i] = cfg_data;
        else         byp_inc[i]   = cfg_data;
      end
      sum[i] = {1'b0, acc[i]} + {1'b0, active_inc[i]};
    end
  end

  always_comb begin
    lock_nxt = lock_cnt;
    if (apply)                    lock_nxt = '0;
    else if (lock_cnt < LOCK_MAX) lock_nxt = lock_cnt + LW'(1);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_inc[i]   <= '0;
        shadow_phase[i] <= '0;
        active_inc[i]   <= '0;
        acc[i]          <= '0;
      end
      ce       <= '0;
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_inc[i]   <= byp_inc[i];
        shadow_phase[i] <= byp_phase[i];
        if (apply) begin
          active_inc[i] <= byp_inc[i];
          acc[i]        <= byp_phase[i];
          ce[i]         <= 1'b0;
        end else if (run) begin
          acc[i] <= sum[i][ACC_W-1:0];
          ce[i]  <= sum[i][ACC_W];
        end else begin
          ce[i] <= 1'b0;
        end
      end
      lock_cnt <= lock_nxt;
      locked   <= (lock_nxt == LOCK_MAX);
    end
  end

  // The accumulator MSB is already a register output, so it is glitch-free.
  always_comb begin
    clk_out = '0;
    for (int i = 0; i < NUM_CH; i++) clk_out[i] = acc[i][ACC_W-1];
  end

endmodule

// File: tb/tb_mf_clken_nco.sv
// Scoreboard bench for mf_clken_nco: a behavioural model predicts ce/clk_out/locked
// per driven cycle; a monitor pops and compares after each rising edge.
module tb_mf_clken_nco;

  localparam int NUM_CH      = 5;
  localparam int ACC_W       = 32;
  localparam int LOCK_CYCLES = 16;

  logic              refclk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic              cfg_wr = 1'b0;
  logic [2:0]        cfg_ch = '0;
  logic              cfg_sel = 1'b0;
  logic [ACC_W-1:0]  cfg_data = '0;
  logic              apply = 1'b0;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] clk_out;
  logic              locked;

  always #5 refclk = ~refclk;

  mf_clken_nco #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK_CYCLES)) dut (
    .refclk(refclk), .rst(rst), .run(run), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .apply(apply),
    .ce(ce), .clk_out(clk_out), .locked(locked)
  );

  typedef struct packed {
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] clk_out;
    logic              locked;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [31:0]       m_sh_inc [NUM_CH];
  logic [31:0]       m_sh_ph  [NUM_CH];
  logic [31:0]       m_inc    [NUM_CH];
  logic [31:0]       m_acc    [NUM_CH];
  logic [NUM_CH-1:0] m_ce;
  int                m_age;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference behaviour: shadows update first so a same-cycle apply sees the new word;
  // a wrap is detected as the accumulator going numerically backwards.
  task automatic modelStep();
    logic [31:0] nxt;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_sh_inc[i] = 0; m_sh_ph[i] = 0; m_inc[i] = 0; m_acc[i] = 0;
      end
      m_ce  = '0;
      m_age = 0;
    end else begin
      if (cfg_wr && cfg_ch < NUM_CH) begin
        if (cfg_sel) m_sh_ph[cfg_ch] = cfg_data;
        else         m_sh_inc[cfg_ch] = cfg_data;
      end
      if (apply) begin
        for (int i = 0; i < NUM_CH; i++) begin
          m_inc[i] = m_sh_inc[i];
          m_acc[i] = m_sh_ph[i];
        end
        m_ce  = '0;
        m_age = 0;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (run) begin
            nxt      = m_acc[i] + m_inc[i];
            m_ce[i]  = (nxt < m_acc[i]);
            m_acc[i] = nxt;
          end else begin
            m_ce[i] = 1'b0;
          end
        end
        if (m_age < 1000) m_age++;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rn, input logic wr, input logic [2:0] ch,
                               input logic sel, input logic [31:0] data, input logic ap);
    exp_t e;
    @(negedge refclk);
    rst = r; run = rn; cfg_wr = wr; cfg_ch = ch; cfg_sel = sel; cfg_data = data; apply = ap;
    modelStep();
    e.ce = m_ce;
    for (int i = 0; i < NUM_CH; i++) e.clk_out[i] = m_acc[i][31];
    e.locked = (m_age >= LOCK_CYCLES);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic rn);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, rn, 1'b0, 3'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic writeCfg(input logic [2:0] ch, input logic sel, input logic [31:0] data);
    applyStimulus(1'b0, 1'b0, 1'b1, ch, sel, data, 1'b0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge refclk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("ce", 32'(ce), 32'(e.ce));
        checkOutput("clk_out", 32'(clk_out), 32'(e.clk_out));
        checkOutput("locked", 32'(locked), 32'(e.locked));
      end
    end
  end

  initial begin
    int wait_cycles;
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 1'b0);
    idle(3, 1'b1);

    // Quarter-rate channel 0 and an antiphase copy on channel 1
    writeCfg(3'd0, 1'b0, 32'h4000_0000);
    writeCfg(3'd1, 1'b0, 32'h4000_0000);
    writeCfg(3'd1, 1'b1, 32'h8000_0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 1'b1);
    idle(20, 1'b1);

    // Pause and resume mid-stream
    idle(10, 1'b0);
    idle(12, 1'b1);

    // Write bypassed straight into a same-cycle apply
    applyStimulus(1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 32'h1000_0000, 1'b1);
    idle(34, 1'b1);

    // Out-of-range channel writes must be ignored
    writeCfg(3'd7, 1'b0, 32'hFFFF_FFFF);
    writeCfg(3'd5, 1'b1, 32'h8000_0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 1'b1);
    idle(10, 1'b1);

    // Non-power-of-two increments, applied while stopped
    writeCfg(3'd3, 1'b0, 32'h5555_5555);
    writeCfg(3'd4, 1'b0, $urandom);
    writeCfg(3'd4, 1'b1, $urandom);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 1'b1);
    idle(3, 1'b0);
    idle(40, 1'b1);

    for (int k = 0; k < 60; k++)
      applyStimulus(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 32'h3FFF_FFFF)) : $urandom,
                    ($urandom_range(0, 7) == 0));
    idle(20, 1'b1);

    // Mid-stream reset with competing apply/write, then relock
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 32'h4000_0000, 1'b1);
    idle(20, 1'b1);
    writeCfg(3'd0, 1'b0, 32'h2000_0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 32'd0, 1'b1);
    idle(20, 1'b1);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge refclk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) checkOutput("drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mf_clken_nco.md
MF_CLKEN_NCO -- requirements
Module: mf_clken_nco

Interface
- REQ-001: Parameter NUM_CH, default 5, number of independent output channels (1..8).
- REQ-002: Parameter ACC_W, default 32, phase-accumulator width in bits (16..48).
- REQ-003: Parameter LOCK_CYCLES, default 16, cycles from reset or apply until locked asserts (1..1023).
- REQ-004: refclk  in  1  single clock; all logic on its rising edge.
- REQ-005: rst  in  1  synchronous, active-high reset.
- REQ-006: run  in  1  1 = accumulators advance; 0 = accumulators hold.
- REQ-007: cfg_wr  in  1  one-cycle write strobe into the shadow registers.
- REQ-008: cfg_ch  in  3  channel index for cfg_wr.
- REQ-009: cfg_sel  in  1  0 = increment shadow, 1 = phase shadow.
- REQ-010: cfg_data  in  ACC_W  value written.
- REQ-011: apply  in  1  one-cycle strobe that loads all shadows into the active state simultaneously.
- REQ-012: ce  out  NUM_CH  per-channel one-cycle clock-enable pulse on accumulator wrap.
- REQ-013: clk_out  out  NUM_CH  per-channel square wave, equal to the accumulator MSB.
- REQ-014: locked  out  1  configuration stable for LOCK_CYCLES cycles.

Function
- REQ-015: Each channel shall hold a shadow increment, a shadow phase, an active increment and an ACC_W-bit accumulator.
- REQ-016: On cfg_wr with cfg_ch < NUM_CH, the shadow register selected by cfg_sel shall take cfg_data at the next edge.
- REQ-017: cfg_wr with cfg_ch >= NUM_CH shall be ignored, with no state change.
- REQ-018: While run=1 and no apply, each accumulator shall update to (acc + active_inc) mod 2^ACC_W every cycle.
- REQ-019: ce[i] shall be a register equal to the carry-out of that addition, so it is high for exactly one cycle per wrap and aligned with the wrapped accumulator value.
- REQ-020: clk_out[i] shall equal accumulator bit ACC_W-1 (registered, glitch-free).
- REQ-021: While run=0, accumulators shall hold, ce shall be 0, and clk_out shall hold.
- REQ-022: active_inc = 0 shall stop the channel: ce[i] stays 0 and clk_out[i] stays constant.
- REQ-023: On apply, at the next edge, for every channel: active_inc <= shadow increment; acc <= shadow phase; ce <= 0. This holds regardless of run.
- REQ-024: cfg_wr and apply in the same cycle: the written value shall be bypassed, so apply loads the new cfg_data for the addressed shadow, and the shadow also stores it.
- REQ-025: Lock counter: reset to 0 by rst or apply; increments each cycle while below LOCK_CYCLES; saturates at LOCK_CYCLES.
- REQ-026: locked shall be a register, high iff lock counter == LOCK_CYCLES.
- REQ-027: locked shall drop in the cycle after apply.
- REQ-028: locked shall not depend on run.
- REQ-029: Frequency relationship: f_ce[i] = f_refclk * active_inc / 2^ACC_W, exact over 2^ACC_W cycles.
- REQ-030: The output period may jitter by one refclk cycle when the increment is not a power of two.

Reset
- REQ-031: When rst=1, at the next edge: all shadows, active increments and accumulators = 0; ce = 0; clk_out = 0; locked = 0; lock counter = 0.
- REQ-032: rst shall take priority over apply, cfg_wr and run in the same cycle.
- REQ-033: Reset mid-operation shall discard all configuration.
- REQ-034: After rst deasserts, locked shall rise exactly LOCK_CYCLES cycles later.

Verification
- REQ-035: ACC_W=32, ch0 inc=0x4000_0000, apply, run=1 -> ce[0] pulses every 4 cycles; clk_out[0] is 2 high / 2 low.
- REQ-036: ch0 and ch1 inc=0x4000_0000, ch1 phase=0x8000_0000, apply -> clk_out[1] = ~clk_out[0] every cycle; ce pulses 2 cycles apart.
- REQ-037: apply at cycle T, LOCK_CYCLES=16 -> locked=0 from T+1 through T+16, and 1 at T+17.
- REQ-038: cfg_wr ch=2 sel=0 data=0x1000_0000 with apply in the same cycle -> ch2 wraps every 16 cycles immediately.
- REQ-039: cfg_wr cfg_ch=7 with NUM_CH=5 -> no change to any channel. inc=0 -> ce never asserts.
- REQ-040: run=0 for 10 cycles mid-stream -> accumulators frozen, ce=0. Resuming run continues the pulse sequence with no lost or extra pulse.
- REQ-041: rst asserted mid-stream -> all outputs 0 at the next edge, and locked rises LOCK_CYCLES cycles after release.
